// File: rtl/risc_pkg.sv
// Shared datapath widths, requester ids and small helpers for the writeback path.
package risc_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU,
        REQ_MEM
    } req_id_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination mask: set by issue-stage allocation, cleared by committed writebacks.
module wb_scoreboard
    import risc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    input  logic                  commit_we,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazard
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    always_comb begin
        alloc_ready = !pending_q[alloc_rd];
        hazard      = pending_q[rs] | pending_q[rt];
        set_mask    = '0;
        clr_mask    = '0;
        if (alloc_valid && alloc_ready) begin
            set_mask = reg_onehot(alloc_rd);
        end
        if (commit_we) begin
            clr_mask = reg_onehot(commit_rd);
        end
        // Set and clear never hit the same bit: a pending register cannot be re-allocated.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto one register-file write port (mem first, with an
// ALU starvation guard) and tracks outstanding destinations for hazard detection.
module regfile_wb_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazard,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0]     rf_data
);

    // The starvation counter is 2 bits wide, so the limit is taken modulo 4.
    localparam logic [1:0] StarveLim = 2'(STARVE_LIMIT);

    logic [1:0]            starve_cnt_q, starve_cnt_d;
    logic                  alu_prio, alu_acc, mem_acc;
    req_id_e               grant_id;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0]     grant_data;

    always_comb begin
        alu_prio  = (starve_cnt_q == StarveLim);
        alu_ready = !rst && (alu_prio || !mem_valid);
        mem_ready = !rst && !(alu_prio && alu_valid);
        alu_acc   = alu_valid && alu_ready;
        mem_acc   = mem_valid && mem_ready;
        grant_id  = mem_acc ? REQ_MEM : REQ_ALU;

        unique case (grant_id)
            REQ_MEM: begin
                grant_rd   = mem_rd;
                grant_data = mem_data;
            end
            default: begin
                grant_rd   = alu_rd;
                grant_data = alu_data;
            end
        endcase

        if (alu_valid && !alu_ready) begin
            starve_cnt_d = alu_prio ? starve_cnt_q : starve_cnt_q + 2'd1;
        end else begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_data      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we        <= alu_acc | mem_acc;
            if (alu_acc | mem_acc) begin
                rf_rd   <= grant_rd;
                rf_data <= grant_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_rd    (alloc_rd),
        .commit_we   (rf_we),
        .commit_rd   (rf_rd),
        .rs          (rs),
        .rt          (rt),
        .hazard      (hazard)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: expected writebacks are queued at drive time and compared on rf_we.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [15:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [15:0] mem_data;
    logic        alloc_valid, alloc_ready;
    logic [4:0]  alloc_rd;
    logic [4:0]  rs, rt;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [15:0] rf_data;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [15:0] data;
    } wb_t;

    wb_t         exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_rd    (alloc_rd),
        .rs          (rs),
        .rt          (rt),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected write lands in the cycle after the accepting edge.
    task automatic push_wb(input logic [4:0] rd, input logic [15:0] data);
        wb_t e;
        e.cyc  = cyc + 1;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        wb_t e;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'(rf_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_cycle", cyc, e.cyc);
                check_eq("wb_rd", 32'(rf_rd), 32'(e.rd));
                check_eq("wb_data", 32'(rf_data), 32'(e.data));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check_eq("wb_missing", 32'(rf_we), 32'd1);
        end
    end

    bit [7:0] alu_win;

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b1; mem_rd = '0; mem_data = '0;
        alloc_valid = 1'b0; alloc_rd = 5'd4;
        rs = 5'd1; rt = 5'd2;
        #12;
        // Reset state
        check_eq("rst_rf_we", 32'(rf_we), 0);
        check_eq("rst_rf_rd", 32'(rf_rd), 0);
        check_eq("rst_rf_data", 32'(rf_data), 0);
        check_eq("rst_alu_ready", 32'(alu_ready), 0);
        check_eq("rst_mem_ready", 32'(mem_ready), 0);
        check_eq("rst_alloc_ready", 32'(alloc_ready), 1);
        check_eq("rst_hazard", 32'(hazard), 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Alloc r5, load writeback BEEF, hazard clears two cycles after accept
        alloc_valid = 1'b1; alloc_rd = 5'd5; #1;
        check_eq("alloc5_ready", 32'(alloc_ready), 1);
        step();
        alloc_valid = 1'b0; rs = 5'd5; rt = 5'd0;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 16'hBEEF; #1;
        check_eq("r5_hazard_pre", 32'(hazard), 1);
        check_eq("r5_mem_ready", 32'(mem_ready), 1);
        push_wb(5'd5, 16'hBEEF);
        step();
        mem_valid = 1'b0; #1;
        check_eq("r5_hazard_n1", 32'(hazard), 1);
        step();
        check_eq("r5_hazard_n2", 32'(hazard), 0);
        check_eq("hold_we", 32'(rf_we), 0);
        check_eq("hold_rd", 32'(rf_rd), 5);
        check_eq("hold_data", 32'(rf_data), 32'hBEEF);

        // WAW stall on r7 until its writeback commits
        alloc_valid = 1'b1; alloc_rd = 5'd7; #1;
        check_eq("r7_first_ready", 32'(alloc_ready), 1);
        step();
        check_eq("r7_second_ready", 32'(alloc_ready), 0);
        step();
        check_eq("r7_stall", 32'(alloc_ready), 0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 16'h1234; #1;
        check_eq("r7_alu_ready", 32'(alu_ready), 1);
        push_wb(5'd7, 16'h1234);
        step();
        alu_valid = 1'b0; #1;
        check_eq("r7_stall_commit", 32'(alloc_ready), 0);
        step();
        check_eq("r7_realloc_ready", 32'(alloc_ready), 1);
        step();
        alloc_valid = 1'b0; rs = 5'd7; rt = 5'd0; #1;
        check_eq("r7_pending_again", 32'(hazard), 1);

        // Alloc r3 on the same edge as the commit of r9
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        step();
        alloc_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 16'h0909;
        push_wb(5'd9, 16'h0909);
        step();
        mem_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd3; rs = 5'd9; rt = 5'd9; #1;
        check_eq("r3_alloc_ready", 32'(alloc_ready), 1);
        check_eq("r9_hazard_commit", 32'(hazard), 1);
        step();
        alloc_valid = 1'b0; rs = 5'd3; rt = 5'd3; #1;
        check_eq("r3_pending", 32'(hazard), 1);
        rs = 5'd9; rt = 5'd9; #1;
        check_eq("r9_cleared", 32'(hazard), 0);

        // Both requesters valid: mem wins three times, then alu is forced through
        alu_win = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 16'hA000 + 16'(i);
            mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 16'hB000 + 16'(i); #1;
            check_eq($sformatf("starve_alu_ready_%0d", i), 32'(alu_ready), 32'(alu_win[i]));
            check_eq($sformatf("starve_mem_ready_%0d", i), 32'(mem_ready), 32'(!alu_win[i]));
            if (alu_win[i]) push_wb(5'd10, 16'hA000 + 16'(i));
            else push_wb(5'd11, 16'hB000 + 16'(i));
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();

        // Reset between accept and commit discards the write and the scoreboard
        alloc_valid = 1'b1; alloc_rd = 5'd12;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 16'h2020;
        step();
        rst = 1'b1;
        alloc_valid = 1'b0; alu_valid = 1'b1; alloc_rd = 5'd12;
        rs = 5'd12; rt = 5'd7; #1;
        check_eq("mid_rst_rf_we", 32'(rf_we), 0);
        check_eq("mid_rst_alu_ready", 32'(alu_ready), 0);
        check_eq("mid_rst_mem_ready", 32'(mem_ready), 0);
        check_eq("mid_rst_hazard", 32'(hazard), 0);
        check_eq("mid_rst_alloc_ready", 32'(alloc_ready), 1);
        check_eq("mid_rst_rf_data", 32'(rf_data), 0);
        step();
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b0;
        step();
        step();
        step();
        check_eq("post_rst_rf_we", 32'(rf_we), 0);
        check_eq("post_rst_hazard", 32'(hazard), 0);

        check_eq("sb_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
